// File: rtl/alpha_blend_fader.sv
// Alpha blender: mixes an N-channel foreground pixel over a background colour with rounding.
// Alpha comes from a static value or from a frame-stepped fade engine.
module alpha_blend_fader #(
    parameter int unsigned CH      = 3,
    parameter int unsigned CW      = 8,
    parameter int unsigned ALPHA_W = 9,
    parameter int unsigned SYNC_W  = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [CH*CW-1:0]     in_data,
    input  logic [SYNC_W-1:0]    in_sync,
    input  logic [CH*CW-1:0]     bg_color,
    input  logic [ALPHA_W-1:0]   alpha_static,
    input  logic                 fade_en,
    input  logic                 fade_start,
    input  logic                 fade_dir,
    input  logic [ALPHA_W-1:0]   fade_step,
    input  logic                 frame_start,
    output logic                 out_valid,
    output logic [CH*CW-1:0]     out_data,
    output logic [SYNC_W-1:0]    out_sync,
    output logic [ALPHA_W-1:0]   alpha_cur,
    output logic                 fade_busy
);
    localparam int unsigned PW = CW + ALPHA_W - 1;
    localparam int unsigned SW = CW + ALPHA_W;
    localparam logic [ALPHA_W-1:0] FULL = {1'b1, {(ALPHA_W-1){1'b0}}};
    localparam logic [SW-1:0]      HALF = SW'(FULL >> 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic                 dir_q, dir_d;
    logic [ALPHA_W-1:0]   step_q, step_d;
    logic [ALPHA_W-1:0]   alpha_q, alpha_d;

    logic [CH-1:0][PW-1:0] pf_q, pf_d, pb_q, pb_d;
    logic [CH*CW-1:0]      res_q, res_d;
    logic [1:0]            valid_q, valid_d;
    logic [SYNC_W-1:0]     sync1_q, sync1_d, sync2_q, sync2_d;

    logic [ALPHA_W-1:0]   a_sel, a_eff, a_inv;
    logic [ALPHA_W:0]     alpha_up;
    logic [SW-1:0]        sum;

    // Stage 1: alpha select/clamp and per-channel products.
    always_comb begin
        a_sel = fade_en ? alpha_q : alpha_static;
        a_eff = (a_sel > FULL) ? FULL : a_sel;
        a_inv = FULL - a_eff;
        pf_d  = '0;
        pb_d  = '0;
        for (int c = 0; c < CH; c++) begin
            pf_d[c] = PW'(in_data[c*CW +: CW]) * PW'(a_eff);
            pb_d[c] = PW'(bg_color[c*CW +: CW]) * PW'(a_inv);
        end
    end

    // Stage 2: rounded sum; the result always fits in CW bits.
    always_comb begin
        res_d = '0;
        sum   = '0;
        for (int c = 0; c < CH; c++) begin
            sum = SW'(pf_q[c]) + SW'(pb_q[c]) + HALF;
            res_d[c*CW +: CW] = CW'(sum >> (ALPHA_W - 1));
        end
        valid_d = {valid_q[0], in_valid};
        sync1_d = in_sync;
        sync2_d = sync1_q;
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        step_d   = step_q;
        alpha_d  = alpha_q;
        alpha_up = {1'b0, alpha_q} + {1'b0, step_q};
        if (fade_start) begin
            // A start always wins over a coincident frame tick.
            state_d = StRun;
            dir_d   = fade_dir;
            if (fade_step == '0) begin
                step_d = ALPHA_W'(1);
            end else if (fade_step > FULL) begin
                step_d = FULL;
            end else begin
                step_d = fade_step;
            end
        end else if (state_q == StRun && frame_start) begin
            if (dir_q) begin
                alpha_d = (alpha_up > {1'b0, FULL}) ? FULL : alpha_up[ALPHA_W-1:0];
                if (alpha_d == FULL) state_d = StIdle;
            end else begin
                alpha_d = (alpha_q < step_q) ? '0 : alpha_q - step_q;
                if (alpha_d == '0) state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            dir_q   <= 1'b0;
            step_q  <= '0;
            alpha_q <= FULL;
            pf_q    <= '0;
            pb_q    <= '0;
            res_q   <= '0;
            valid_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            alpha_q <= alpha_d;
            pf_q    <= pf_d;
            pb_q    <= pb_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign out_valid = valid_q[1];
    assign out_data  = res_q;
    assign out_sync  = sync2_q;
    assign alpha_cur = alpha_q;
    assign fade_busy = (state_q == StRun);

endmodule

// File: tb/tb_alpha_blend_fader.sv
// Self-checking bench: behavioural model compared every cycle, plus directed literal checks.
module tb_alpha_blend_fader;
    localparam int CH = 3, CW = 8, ALPHA_W = 9, SYNC_W = 3;
    localparam int FULL = 1 << (ALPHA_W - 1);

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic [CH*CW-1:0]     in_data = '0;
    logic [SYNC_W-1:0]    in_sync = '0;
    logic [CH*CW-1:0]     bg_color = '0;
    logic [ALPHA_W-1:0]   alpha_static = '0;
    logic                 fade_en = 1'b0;
    logic                 fade_start = 1'b0;
    logic                 fade_dir = 1'b0;
    logic [ALPHA_W-1:0]   fade_step = '0;
    logic                 frame_start = 1'b0;
    logic                 out_valid;
    logic [CH*CW-1:0]     out_data;
    logic [SYNC_W-1:0]    out_sync;
    logic [ALPHA_W-1:0]   alpha_cur;
    logic                 fade_busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    alpha_blend_fader #(.CH(CH), .CW(CW), .ALPHA_W(ALPHA_W), .SYNC_W(SYNC_W)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_sync(in_sync), .bg_color(bg_color), .alpha_static(alpha_static),
        .fade_en(fade_en), .fade_start(fade_start), .fade_dir(fade_dir),
        .fade_step(fade_step), .frame_start(frame_start), .out_valid(out_valid),
        .out_data(out_data), .out_sync(out_sync), .alpha_cur(alpha_cur),
        .fade_busy(fade_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [CH*CW-1:0] blend(input logic [CH*CW-1:0] f, b, input int a);
        logic [CH*CW-1:0] r = '0;
        for (int c = 0; c < CH; c++) begin
            int fc = int'(f[c*CW +: CW]);
            int bc = int'(b[c*CW +: CW]);
            r[c*CW +: CW] = CW'((fc * a + bc * (FULL - a) + FULL / 2) / FULL);
        end
        return r;
    endfunction

    // Reference model state
    int               m_alpha = FULL, m_step = 1;
    bit               m_busy = 0, m_dir = 0;
    bit               e1_v = 0, e2_v = 0;
    logic [CH*CW-1:0] e1_d = '0, e2_d = '0;
    logic [SYNC_W-1:0] e1_s = '0, e2_s = '0;

    always @(posedge clock) begin
        int ea, na;
        bit nb;
        if (!reset_n) begin
            e1_v <= 0; e2_v <= 0; e1_d <= '0; e2_d <= '0; e1_s <= '0; e2_s <= '0;
            m_alpha <= FULL; m_busy <= 0;
        end else begin
            ea = fade_en ? m_alpha : int'(alpha_static);
            if (ea > FULL) ea = FULL;
            e1_v <= in_valid; e1_d <= blend(in_data, bg_color, ea); e1_s <= in_sync;
            e2_v <= e1_v;     e2_d <= e1_d;                          e2_s <= e1_s;
            na = m_alpha;
            nb = m_busy;
            if (fade_start) begin
                nb = 1;
                m_dir <= fade_dir;
                m_step <= (fade_step == 0) ? 1 : ((int'(fade_step) > FULL) ? FULL
                                                                            : int'(fade_step));
            end else if (m_busy && frame_start) begin
                if (m_dir) begin
                    na = (m_alpha + m_step > FULL) ? FULL : m_alpha + m_step;
                    if (na == FULL) nb = 0;
                end else begin
                    na = (m_alpha - m_step < 0) ? 0 : m_alpha - m_step;
                    if (na == 0) nb = 0;
                end
            end
            m_alpha <= na;
            m_busy <= nb;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("cyc_out_valid", 32'(out_valid), 32'(e2_v));
            chk("cyc_out_data", 32'(out_data), 32'(e2_d));
            chk("cyc_out_sync", 32'(out_sync), 32'(e2_s));
            chk("cyc_alpha_cur", 32'(alpha_cur), 32'(m_alpha));
            chk("cyc_fade_busy", 32'(fade_busy), 32'(m_busy));
        end
    end

    task automatic pix(input logic [23:0] f, b, input logic [8:0] as, input logic [23:0] exp,
                       input string nm);
        @(posedge clock); #1;
        in_valid = 1; in_data = f; bg_color = b; alpha_static = as; fade_en = 0;
        in_sync = 3'b101;
        @(posedge clock); #1;
        in_valid = 0; in_sync = 3'b000;
        @(posedge clock); #1;
        chk({nm, "_data"}, 32'(out_data), 32'(exp));
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_sync"}, 32'(out_sync), 32'd5);
    endtask

    task automatic start(input bit dir, input int step, input bit with_frame);
        @(posedge clock); #1;
        fade_start = 1; fade_dir = dir; fade_step = 9'(step); frame_start = with_frame;
        @(posedge clock); #1;
        fade_start = 0; frame_start = 0;
    endtask

    task automatic frame();
        @(posedge clock); #1;
        frame_start = 1;
        @(posedge clock); #1;
        frame_start = 0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1;
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_alpha", 32'(alpha_cur), 256);
        reset_n = 1;

        pix(24'h123456, 24'hABCDEF, 9'd256, 24'h123456, "opaque");
        pix(24'h123456, 24'hABCDEF, 9'd0,   24'hABCDEF, "transparent");
        pix(24'h123456, 24'hABCDEF, 9'd300, 24'h123456, "clamp");
        pix(24'hFF01FF, 24'hFF0000, 9'd128, 24'hFF0180, "rounding");
        pix(24'hFFFFFF, 24'hFFFFFF, 9'd77,  24'hFFFFFF, "white");

        // Fade out from reset
        start(0, 64, 0);
        chk("fo_busy0", 32'(fade_busy), 1);
        frame(); chk("fo_a1", 32'(alpha_cur), 192);
        frame(); chk("fo_a2", 32'(alpha_cur), 128);
        frame(); chk("fo_a3", 32'(alpha_cur), 64);
        chk("fo_busy3", 32'(fade_busy), 1);
        frame(); chk("fo_a4", 32'(alpha_cur), 0);
        chk("fo_busy4", 32'(fade_busy), 0);
        frame(); chk("fo_a5", 32'(alpha_cur), 0);

        // Step 0 acts as 1, then climb to 200 and saturate
        start(1, 0, 0);
        frame(); chk("step0", 32'(alpha_cur), 1);
        start(1, 199, 0);
        frame(); chk("to200", 32'(alpha_cur), 200);
        start(1, 100, 0);
        frame(); chk("sat", 32'(alpha_cur), 256);
        chk("sat_busy", 32'(fade_busy), 0);

        // Coincident start and frame: no step
        start(0, 64, 1);
        chk("coinc_a", 32'(alpha_cur), 256);
        chk("coinc_busy", 32'(fade_busy), 1);
        frame(); chk("coinc_a1", 32'(alpha_cur), 192);
        frame(); chk("coinc_a2", 32'(alpha_cur), 128);
        start(1, 64, 0);
        frame(); chk("restart", 32'(alpha_cur), 192);

        // Fade alpha drives the blend once selected
        @(posedge clock); #1;
        fade_en = 1; in_valid = 1; in_data = 24'h0000FF; bg_color = 24'h000000;
        repeat (2) @(posedge clock);
        #1;
        chk("fade_pix", 32'(out_data), 32'h0000BF);
        in_valid = 0; fade_en = 0;

        // Reset mid-run with pixels in flight
        start(0, 10, 0);
        @(posedge clock); #1;
        in_valid = 1; in_data = 24'h555555; in_sync = 3'b111;
        @(posedge clock); #1;
        reset_n = 0;
        @(posedge clock); #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_sync", 32'(out_sync), 0);
        chk("rst_alpha", 32'(alpha_cur), 256);
        chk("rst_busy", 32'(fade_busy), 0);
        reset_n = 1;

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clock); #1;
            in_valid     = 1'($urandom);
            in_data      = 24'($urandom);
            in_sync      = 3'($urandom);
            alpha_static = 9'($urandom);
            fade_en      = 1'($urandom);
            fade_start   = ($urandom_range(0, 40) == 0);
            fade_dir     = 1'($urandom);
            fade_step    = 9'($urandom_range(0, 300));
            frame_start  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 50) == 0) bg_color = 24'($urandom);
            if ($urandom_range(0, 1500) == 0) reset_n = 0;
            else reset_n = 1;
        end
        @(posedge clock); #1;
        in_valid = 0; fade_start = 0; frame_start = 0; reset_n = 1;
        repeat (3) @(posedge clock);
        #1;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alpha_blend_fader.md
Name: alpha_blend_fader

Overview:
- Parametrised successor to the per-channel alpha scaler in the video filter path.
- Blends an N-channel foreground pixel over a programmable background colour with rounding, instead of only scaling towards black.
- Alpha comes from a static value or from a frame-stepped fade engine used for OSD and menu fade-in/out.
- Sits between the line-buffer output and the HDMI encoder. It carries valid and sync sideband through with matched latency.

Parameters:
- CH, 3, number of colour channels.
- CW, 8, bits per channel.
- ALPHA_W, 9, alpha width. Full scale is FULL = 2^(ALPHA_W-1); for the default, 256 means opaque.
- SYNC_W, 3, sideband width (hsync, vsync, de), delayed with the pixel.

Ports:
- clock  in  1  pixel clock; all logic is on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  pixel qualifier.
- in_data  in  CH*CW  foreground pixel; channel 0 is in the LSBs.
- in_sync  in  SYNC_W  sideband aligned with in_data.
- bg_color  in  CH*CW  background colour; quasi-static.
- alpha_static  in  ALPHA_W  alpha used when fade_en=0.
- fade_en  in  1  1 = use the fade engine alpha (alpha_cur).
- fade_start  in  1  single-cycle pulse that starts a fade.
- fade_dir  in  1  1 = fade in (towards FULL), 0 = fade out (towards 0); sampled with fade_start.
- fade_step  in  ALPHA_W  alpha change per frame; sampled with fade_start.
- frame_start  in  1  single-cycle pulse, once per frame.
- out_valid  out  1  qualifier for out_data.
- out_data  out  CH*CW  blended pixel.
- out_sync  out  SYNC_W  delayed sideband.
- alpha_cur  out  ALPHA_W  current fade engine alpha.
- fade_busy  out  1  high while a fade is running.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - out_valid=0, out_data=0, out_sync=0.
  - alpha_cur=FULL, fade_busy=0, FSM=IDLE, both pipeline stages cleared.
  - A reset during a fade aborts it.
- Effective alpha a:
  - a = fade_en ? alpha_cur : alpha_static.
  - a is clamped to FULL (any value above FULL acts as FULL).
  - a is sampled in the same cycle as in_data.
- Blend, per channel c with foreground f and background b:
  - out = (f*a + b*(FULL-a) + FULL/2) >> (ALPHA_W-1).
  - Each product is CW+ALPHA_W-1 bits wide; the sum is CW+ALPHA_W bits.
  - The result cannot exceed 2^CW-1, so no saturation logic is needed; truncate to CW bits.
- Pipeline:
  - Stage 1 registers the 2*CH products and a.
  - Stage 2 registers the rounded, shifted sum.
  - Latency is exactly 2 cycles.
  - in_valid and in_sync are delayed 2 cycles every cycle, valid or not.
  - No backpressure. Invalid cycles propagate as out_valid=0, and out_data still updates (don't-care).
- Fade FSM, IDLE:
  - fade_start goes to RUN. It latches dir, and latches step = (fade_step==0) ? 1 : min(fade_step, FULL).
  - fade_busy=1 from the cycle after fade_start.
- Fade FSM, RUN:
  - On each frame_start, alpha_cur moves by step: +step saturating at FULL, or -step saturating at 0.
  - When the updated value equals the target (FULL or 0), go to IDLE; fade_busy=0 in that same update cycle.
  - If alpha_cur already equals the target when the fade starts, the first frame_start leaves it unchanged and returns to IDLE.
- Restart: fade_start while in RUN re-latches dir and step and continues from the present alpha_cur (no jump).
- fade_start and frame_start in the same cycle: the start wins; there is no step that cycle, and the first step happens on the next frame_start.
- alpha_cur changes become visible to pixels sampled from the cycle after the update.
- fade_en changes only the alpha select; the FSM keeps running regardless of fade_en.

Test Plan:
- Full opaque: fade_en=0, alpha_static=256, in_data=0x123456, bg=0xABCDEF, in_valid=1 at cycle t -> out_data=0x123456 with out_valid=1 at t+2; in_sync pattern appears at t+2.
- Full transparent and clamp: alpha_static=0 -> out=0xABCDEF; alpha_static=300 -> out=0x123456.
- Rounding: f=0xFF, b=0x00, a=128 -> 0x80; f=0x01, b=0x00, a=128 -> 0x01 ((128+128)>>8); f=0xFF, b=0xFF, any a -> 0xFF.
- Fade out: fade_start with dir=0, step=64 from reset -> alpha_cur 192, 128, 64, 0 on 4 successive frame_start; fade_busy falls with the 0 update; a 5th frame_start leaves 0.
- Fade corner cases:
  - step=0 -> moves by 1 per frame.
  - step=100 with dir=1 from alpha_cur=200 -> saturates at 256.
  - fade_start coincident with frame_start -> no step that cycle.
  - Restart mid-fade with dir=1 from 128 -> 192 on the next frame.
- Reset mid-operation: reset_n=0 during RUN with pixels in flight -> next cycle out_valid=0, out_data=0, out_sync=0, alpha_cur=256, fade_busy=0.
